// File: rtl/egg_timer_multi_mode.sv
// ============================================================================
// Module   : egg_timer_multi_mode
// Purpose  : MM:SS kitchen timer with set/arm/run/pause/alarm modes and BCD display.
//            Define EGG_TIMER_TONE_EN for a square-wave alarm tone (else steady).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module egg_timer_multi_mode #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned MAX_MIN    = 99,
    parameter int unsigned ALARM_SECS = 10,
    parameter int unsigned TONE_DIV   = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       cook_time,
    input  logic       minutes,
    input  logic       seconds,
    input  logic       start,
    output logic [3:0] m_tens,
    output logic [3:0] m_ones,
    output logic [2:0] s_tens,
    output logic [3:0] s_ones,
    output logic [2:0] state,
    output logic       timer_on,
    output logic       timer_done,
    output logic       speaker
);

    localparam logic [2:0]  c_IDLE       = 3'd0;
    localparam logic [2:0]  c_SET        = 3'd1;
    localparam logic [2:0]  c_ARMED      = 3'd2;
    localparam logic [2:0]  c_RUN        = 3'd3;
    localparam logic [2:0]  c_PAUSE      = 3'd4;
    localparam logic [2:0]  c_ALARM      = 3'd5;
    localparam logic [31:0] c_TICK_LAST  = 32'(TICK_DIV - 1);
    localparam logic [6:0]  c_MAX_MIN    = 7'(MAX_MIN);
    localparam logic [7:0]  c_ALARM_LAST = 8'(ALARM_SECS - 1);

    logic        btn_min_q, btn_sec_q, btn_start_q;
    logic [2:0]  fsm_q, fsm_d;
    logic [6:0]  min_q, min_d, rld_min_q, rld_min_d;
    logic [5:0]  sec_q, sec_d, rld_sec_q, rld_sec_d;
    logic [31:0] presc_q, presc_d;
    logic [7:0]  alm_q, alm_d;

    logic w_min_press, w_sec_press, w_start_press;
    logic w_tick, w_nonzero, w_last;

    assign w_min_press   = minutes & ~btn_min_q;
    assign w_sec_press   = seconds & ~btn_sec_q;
    assign w_start_press = start & ~btn_start_q;
    assign w_tick        = (presc_q == c_TICK_LAST);
    assign w_nonzero     = (min_q != 7'd0) || (sec_q != 6'd0);
    // In RUN the count is never 00:00, so 00:01 is the last second before the alarm.
    assign w_last        = (min_q == 7'd0) && (sec_q == 6'd1);

    always_comb begin
        fsm_d     = fsm_q;
        min_d     = min_q;
        sec_d     = sec_q;
        rld_min_d = rld_min_q;
        rld_sec_d = rld_sec_q;
        presc_d   = presc_q;
        alm_d     = alm_q;
        case (fsm_q)
            c_IDLE: begin
                if (cook_time) fsm_d = c_SET;
            end
            c_SET: begin
                if (!cook_time) begin
                    fsm_d     = c_ARMED;
                    rld_min_d = min_q;
                    rld_sec_d = sec_q;
                end else begin
                    if (w_sec_press) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                    if (w_min_press) min_d = (min_q >= c_MAX_MIN) ? 7'd0 : min_q + 7'd1;
                end
            end
            c_ARMED: begin
                if (w_start_press && w_nonzero) begin
                    fsm_d   = c_RUN;
                    presc_d = '0;
                end else if (cook_time) begin
                    fsm_d = c_SET;
                end
            end
            c_RUN: begin
                if (w_start_press) begin
                    fsm_d = c_PAUSE;
                end else begin
                    presc_d = w_tick ? 32'd0 : presc_q + 32'd1;
                    if (w_tick) begin
                        if (sec_q == 6'd0) begin
                            min_d = min_q - 7'd1;
                            sec_d = 6'd59;
                        end else begin
                            sec_d = sec_q - 6'd1;
                        end
                        if (w_last) begin
                            fsm_d = c_ALARM;
                            alm_d = 8'd0;
                        end
                    end
                end
            end
            c_PAUSE: begin
                if (w_start_press) fsm_d = c_RUN;
            end
            c_ALARM: begin
                if (w_start_press) begin
                    fsm_d   = c_IDLE;
                    min_d   = rld_min_q;
                    sec_d   = rld_sec_q;
                    presc_d = '0;
                end else begin
                    presc_d = w_tick ? 32'd0 : presc_q + 32'd1;
                    if (w_tick) begin
                        if (alm_q == c_ALARM_LAST) begin
                            fsm_d = c_IDLE;
                            min_d = rld_min_q;
                            sec_d = rld_sec_q;
                        end else begin
                            alm_d = alm_q + 8'd1;
                        end
                    end
                end
            end
            default: fsm_d = c_IDLE;
        endcase
    end

    // Edge registers track the buttons even while frozen, so a held button is not a press later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_min_q   <= 1'b0;
            btn_sec_q   <= 1'b0;
            btn_start_q <= 1'b0;
            fsm_q       <= c_IDLE;
            min_q       <= '0;
            sec_q       <= '0;
            rld_min_q   <= '0;
            rld_sec_q   <= '0;
            presc_q     <= '0;
            alm_q       <= '0;
            m_tens      <= '0;
            m_ones      <= '0;
            s_tens      <= '0;
            s_ones      <= '0;
            timer_on    <= 1'b0;
            timer_done  <= 1'b0;
        end else begin
            btn_min_q   <= minutes;
            btn_sec_q   <= seconds;
            btn_start_q <= start;
            if (enable) begin
                fsm_q      <= fsm_d;
                min_q      <= min_d;
                sec_q      <= sec_d;
                rld_min_q  <= rld_min_d;
                rld_sec_q  <= rld_sec_d;
                presc_q    <= presc_d;
                alm_q      <= alm_d;
                m_tens     <= 4'(min_q / 7'd10);
                m_ones     <= 4'(min_q % 7'd10);
                s_tens     <= 3'(sec_q / 6'd10);
                s_ones     <= 4'(sec_q % 6'd10);
                timer_on   <= (fsm_d == c_RUN);
                timer_done <= (fsm_d == c_ALARM) && (fsm_q != c_ALARM);
            end
        end
    end

    assign state = fsm_q;

`ifdef EGG_TIMER_TONE_EN
    localparam logic [15:0] c_TONE_LAST = 16'(TONE_DIV - 1);
    logic [15:0] tone_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speaker <= 1'b0;
            tone_q  <= '0;
        end else if (enable) begin
            if (fsm_d != c_ALARM) begin
                speaker <= 1'b0;
                tone_q  <= '0;
            end else if (fsm_q != c_ALARM) begin
                speaker <= 1'b1;
                tone_q  <= '0;
            end else if (tone_q == c_TONE_LAST) begin
                speaker <= ~speaker;
                tone_q  <= '0;
            end else begin
                tone_q <= tone_q + 16'd1;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speaker <= 1'b0;
        end else if (enable) begin
            speaker <= (fsm_d == c_ALARM);
        end
    end
`endif

endmodule

`default_nettype wire
